// File: rtl/psram_arbiter.sv
// Two-requester round-robin arbiter in front of a single PSRAM controller.
// One transaction in flight at a time: IDLE -> BUSY -> RESP -> IDLE, with a wait-cycle timeout.
module psram_arbiter #(
   parameter int AW      = 24,
   parameter int TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_valid_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [31:0]   m0_wdata_i,
   input  logic [3:0]    m0_wstrb_i,
   output logic [31:0]   m0_rdata_o,
   output logic          m0_ready_o,
   input  logic          m1_valid_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [31:0]   m1_wdata_i,
   input  logic [3:0]    m1_wstrb_i,
   output logic [31:0]   m1_rdata_o,
   output logic          m1_ready_o,
   output logic          s_valid_o,
   output logic [AW-1:0] s_addr_o,
   output logic [31:0]   s_wdata_o,
   output logic [3:0]    s_wstrb_o,
   input  logic [31:0]   s_rdata_i,
   input  logic          s_ready_i,
   output logic          tmo_o,
   output logic          tmo_sticky_o,
   input  logic          tmo_clr_i,
   output logic          gnt_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        gnt_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [31:0] resp, resp_nxt;
   logic        sticky_nxt;
   logic        hit_tmo;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         gnt_o        <= 1'b1;
         cnt          <= 8'd0;
         resp         <= 32'd0;
         tmo_sticky_o <= 1'b0;
      end else begin
         state        <= state_nxt;
         gnt_o        <= gnt_nxt;
         cnt          <= cnt_nxt;
         resp         <= resp_nxt;
         tmo_sticky_o <= sticky_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_o;
      cnt_nxt   = cnt;
      resp_nxt  = resp;
      hit_tmo   = 1'b0;
      case (state)
         IDLE: begin
            if (m0_valid_i || m1_valid_i) begin
               state_nxt = BUSY;
               cnt_nxt   = 8'd0;
               // Under contention the requester not served last wins.
               gnt_nxt   = (m0_valid_i && m1_valid_i) ? ~gnt_o : m1_valid_i;
            end
         end
         BUSY: begin
            if (s_ready_i) begin
               resp_nxt  = s_rdata_i;
               state_nxt = RESP;
            end else if (cnt == TMO_LAST) begin
               hit_tmo   = 1'b1;
               resp_nxt  = 32'hFFFF_FFFF;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A clear in the same cycle as a new timeout wins.
      sticky_nxt = tmo_clr_i ? 1'b0 : (hit_tmo ? 1'b1 : tmo_sticky_o);
   end

   assign tmo_o      = hit_tmo;
   assign s_valid_o  = (state == BUSY);
   assign s_addr_o   = gnt_o ? m1_addr_i  : m0_addr_i;
   assign s_wdata_o  = gnt_o ? m1_wdata_i : m0_wdata_i;
   assign s_wstrb_o  = gnt_o ? m1_wstrb_i : m0_wstrb_i;
   assign m0_ready_o = (state == RESP) && !gnt_o;
   assign m1_ready_o = (state == RESP) &&  gnt_o;
   assign m0_rdata_o = resp;
   assign m1_rdata_o = resp;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: transaction-level arbitration model in the responder,
// expected completions queued and checked by an independent monitor on each ready pulse.
module tb_psram_arbiter;

   localparam int AW  = 24;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_valid = 1'b0, m1_valid = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [31:0]   m0_wdata = '0, m1_wdata = '0;
   logic [3:0]    m0_wstrb = '0, m1_wstrb = '0;
   logic [31:0]   m0_rdata, m1_rdata;
   logic          m0_ready, m1_ready;
   logic          s_valid;
   logic [AW-1:0] s_addr;
   logic [31:0]   s_wdata;
   logic [3:0]    s_wstrb;
   logic [31:0]   s_rdata;
   logic          s_ready;
   logic          tmo, tmo_sticky, gnt;
   logic          clr_main = 1'b0, clr_resp = 1'b0;
   wire           tmo_clr = clr_main | clr_resp;

   psram_arbiter #(.AW(AW), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
      .m0_rdata_o(m0_rdata), .m0_ready_o(m0_ready),
      .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
      .m1_rdata_o(m1_rdata), .m1_ready_o(m1_ready),
      .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
      .s_rdata_i(s_rdata), .s_ready_i(s_ready),
      .tmo_o(tmo), .tmo_sticky_o(tmo_sticky), .tmo_clr_i(tmo_clr), .gnt_o(gnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // requester valids as seen by the DUT at the most recent edge
   logic v0_q = 1'b0, v1_q = 1'b0;
   always @(posedge clk) begin
      v0_q <= m0_valid;
      v1_q <= m1_valid;
   end

   // responder controls (written by main only)
   logic        stall = 1'b0, clr_at_tmo = 1'b0;
   int          fix_w = 0;
   logic [31:0] fix_rd = '0;
   logic        use_fix_rd = 1'b0;

   // model state (written by responder only)
   logic        last_g = 1'b1;
   logic        any_tmo = 1'b0;
   logic [32:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic do_req(input int n, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat);
      int t0, k;
      @(posedge clk); #1;
      if (n == 0) begin m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
      else        begin m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
      t0 = cyc;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if ((n == 0) ? m0_ready : m1_ready) break;
      end
      if (k == 200) chk("req_timeout_no_ready", 32'(k), 32'd0);
      lat = cyc - t0;
      @(posedge clk); #1;
      if (n == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
   endtask

   // Downstream responder + arbitration/response model
   initial begin
      logic        g, aborted;
      int          w;
      logic [31:0] rd;
      s_ready = 1'b0;
      s_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst || !s_valid) begin
            if (rst) begin last_g = 1'b1; exp_q.delete(); end
            s_ready = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
         end else begin
            chk("grant_has_request", 32'(v0_q | v1_q), 32'd1);
            if (v0_q && v1_q) g = !last_g;
            else              g = v1_q;
            last_g = g;
            w  = stall ? 1000 : (fix_w != 0 ? fix_w : $urandom_range(1, 10));
            rd = use_fix_rd ? fix_rd : $urandom;
            aborted = 1'b0;
            for (int b = 1; b <= TMO; b++) begin
               if (b > 1) @(negedge clk);
               if (rst) begin aborted = 1'b1; break; end
               chk("s_valid_busy", 32'(s_valid), 32'd1);
               chk("s_addr", 32'(s_addr), 32'(g ? m1_addr : m0_addr));
               chk("s_wdata", s_wdata, g ? m1_wdata : m0_wdata);
               chk("s_wstrb", 32'(s_wstrb), 32'(g ? m1_wstrb : m0_wstrb));
               s_ready  = (b == w);
               s_rdata  = (b == w) ? rd : $urandom;
               clr_resp = (b == TMO) && clr_at_tmo;
               #1 chk("tmo_o", 32'(tmo), 32'((b == TMO) && (b != w)));
               if (b == w) break;
            end
            if (!aborted) begin
               exp_q.push_back({g, (w <= TMO) ? rd : 32'hFFFF_FFFF});
               if (w > TMO) any_tmo = 1'b1;
               @(posedge clk); #1;
               s_ready  = 1'b0;
               clr_resp = 1'b0;
            end
         end
      end
   end

   // Monitor: completions, exclusivity, response-register stability
   initial begin
      logic [32:0] e;
      logic        prev_sv = 1'b0, prev_rst = 1'b1;
      logic [31:0] prev_rd = '0;
      forever begin
         @(negedge clk);
         if (!rst && !prev_rst && !s_valid && !prev_sv) begin
            chk("rdata_stable", m0_rdata, prev_rd);
            chk("rdata_ports_equal", m1_rdata, m0_rdata);
         end
         if (m0_ready || m1_ready) begin
            chk("ready_exclusive", 32'(m0_ready & m1_ready), 32'd0);
            chk("s_valid_in_resp", 32'(s_valid), 32'd0);
            if (exp_q.size() == 0) begin
               chk("ready_unexpected", 32'({m1_ready, m0_ready}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("ready_port", 32'(m1_ready), 32'(e[32]));
               chk("rdata", e[32] ? m1_rdata : m0_rdata, e[31:0]);
               chk("gnt_o", 32'(gnt), 32'(e[32]));
            end
         end
         prev_sv  = s_valid;
         prev_rd  = m0_rdata;
         prev_rst = rst;
      end
   end

   initial begin
      int lat, la, lb;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd1);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
      chk("rst_rdata", m0_rdata, 32'd0);
      chk("rst_tmo", 32'({tmo, tmo_sticky}), 32'd0);
      rst = 1'b0;

      // single read, 3 BUSY cycles: ready in the 5th cycle counting the request cycle
      fix_w = 3; fix_rd = 32'hDEADBEEF; use_fix_rd = 1'b1;
      do_req(0, 24'h000100, 32'h0, 4'h0, lat);
      chk("read_latency", 32'(lat), 32'(1 + 3 + 1 - 1));
      chk("read_rdata", m0_rdata, 32'hDEADBEEF);
      use_fix_rd = 1'b0;

      // write pass-through
      fix_w = 4;
      do_req(1, 24'h7FFFFC, 32'h12345678, 4'b0011, lat);
      chk("write_latency", 32'(lat), 32'd5);
      fix_w = 0;

      // contention, then both kept busy -> alternation checked by the scoreboard
      fork
         do_req(0, 24'h000010, 32'h1, 4'hF, la);
         do_req(1, 24'h000020, 32'h2, 4'hF, lb);
      join
      fork
         begin repeat (2) do_req(0, 24'h000030, $urandom, 4'h0, la); end
         begin repeat (2) do_req(1, 24'h000040, $urandom, 4'h0, lb); end
      join

      // randomized traffic from both requesters
      fork
         begin
            for (int i = 0; i < 25; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               do_req(0, AW'($urandom), $urandom, 4'($urandom), la);
            end
         end
         begin
            for (int j = 0; j < 25; j++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               do_req(1, AW'($urandom), $urandom, 4'($urandom), lb);
            end
         end
      join
      @(negedge clk);
      chk("sticky_after_random", 32'(tmo_sticky), 32'(any_tmo));
      @(posedge clk); #1 clr_main = 1'b1;
      @(posedge clk); #1 clr_main = 1'b0;

      // timeout: sticky set, held, cleared; then clear wins over a coincident set
      stall = 1'b1;
      do_req(1, 24'h000200, 32'h0, 4'h0, lat);
      chk("tmo_latency", 32'(lat), 32'(TMO + 1));
      chk("tmo_sticky_set", 32'(tmo_sticky), 32'd1);
      repeat (3) @(negedge clk);
      chk("tmo_sticky_hold", 32'(tmo_sticky), 32'd1);
      @(posedge clk); #1 clr_main = 1'b1;
      @(posedge clk); #1 clr_main = 1'b0;
      @(negedge clk);
      chk("tmo_sticky_clr", 32'(tmo_sticky), 32'd0);
      do_req(0, 24'h000204, 32'h0, 4'h0, lat);
      chk("tmo_sticky_set2", 32'(tmo_sticky), 32'd1);
      clr_at_tmo = 1'b1;
      do_req(1, 24'h000208, 32'h0, 4'h0, lat);
      @(negedge clk);
      chk("tmo_clr_priority", 32'(tmo_sticky), 32'd0);
      clr_at_tmo = 1'b0;

      // reset in the 2nd BUSY cycle, asynchronous to the clock
      @(posedge clk); #1;
      m0_valid = 1'b1; m0_addr = 24'h000300;
      @(posedge clk);
      @(posedge clk);
      #1 chk("pre_rst_busy", 32'(s_valid), 32'd1);
      #2 rst = 1'b1;
      #1 chk("rst_async_s_valid", 32'(s_valid), 32'd0);
      m0_valid = 1'b0;
      stall = 1'b0;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk("rst_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
         chk("rst_gnt_hold", 32'(gnt), 32'd1);
      end
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
      end
      fork
         do_req(0, 24'h000400, 32'h0, 4'h0, la);
         do_req(1, 24'h000500, 32'h0, 4'h0, lb);
      join
      chk("post_rst_m0_first", 32'(la < lb), 32'd1);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_time_limit: got expired expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

endmodule
